// File: rtl/op_serial_logic_pkg.sv
// rtl/op_serial_logic_pkg.sv - opcode and FSM state definitions shared by the serial logic unit
package op_serial_logic_pkg;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_logic_bit.sv
// rtl/serial_logic_bit.sv - combinational one-bit cell for the serial logic unit
module serial_logic_bit
    import op_serial_logic_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c,
    input  op_e  op,
    output logic r,
    output logic c_next
);

    // Negation is ~a + 1 computed LSB first: the carry starts at 1 and ripples through.
    assign c_next = ~a_i & c;

    always_comb begin
        r = 1'b0;
        case (op)
            OP_NOT:  r = ~a_i;
            OP_AND:  r = a_i & b_i;
            OP_OR:   r = a_i | b_i;
            OP_NEG:  r = ~a_i ^ c;
            default: r = 1'b0;
        endcase
    end

endmodule

// File: rtl/op_serial_logic.sv
// rtl/op_serial_logic.sv - bit-serial NOT/AND/OR/NEG unit, one result bit per clock, LSB first
module op_serial_logic
    import op_serial_logic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_e          state;
    state_e          state_next;
    op_e             op_q;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            r_bit;
    logic            c_next;
    logic            last;

    assign last = (cnt == CW'(N - 1));

    serial_logic_bit u_bit (
        .a_i    (a_sh[0]),
        .b_i    (b_sh[0]),
        .c      (carry),
        .op     (op_q),
        .r      (r_bit),
        .c_next (c_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Result bits are shifted into the top of a_sh as operand bits leave the bottom,
    // so after N shifts the register holds the finished result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            op_q  <= OP_NOT;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op_e'(op);
                        a_sh  <= a;
                        b_sh  <= b;
                        cnt   <= '0;
                        carry <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_sh  <= {r_bit, a_sh[N-1:1]};
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) y <= {r_bit, a_sh[N-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_op_serial_logic.sv
// tb/tb_op_serial_logic.sv - randomized self-checking bench for op_serial_logic against a word-level model
module tb_op_serial_logic;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] y_model;

    op_serial_logic #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] ref_result(input logic [1:0] o, input logic [N-1:0] av,
                                                input logic [N-1:0] bv);
        int unsigned full;
        full = 1 << N;
        case (o)
            2'b00:   return ~av;
            2'b01:   return av & bv;
            2'b10:   return av | bv;
            default: return N'((full - int'(av)) % full);
        endcase
    endfunction

    // Launch one operation with start asserted just before edge t0, then follow it to IDLE.
    task automatic do_op(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input bit hold, input bit disturb);
        logic [N-1:0] exp_y;
        exp_y = ref_result(o, av, bv);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_y_hold", y, y_model);
            if (disturb && k == 2) begin
                start = 1'b1;
                op    = 2'b01;
                a     = 8'hFF;
                b     = N'($urandom);
            end
            if (disturb && k == 4) start = hold;
            if (k != 0 && !disturb) begin
                a = N'($urandom);
                b = N'($urandom);
                op = 2'($urandom);
            end
            step();
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("result", y, exp_y);
        y_model = exp_y;
        step();
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_y", y, y_model);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        y_model = '0;
        step();
        step();
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);
        check("idle_y", y, 0);

        do_op(2'b00, 8'hA5, 8'h00, 0, 0);
        check("not_a5", y, 8'h5A);
        do_op(2'b11, 8'h01, 8'h00, 0, 0);
        check("neg_01", y, 8'hFF);
        do_op(2'b11, 8'h00, 8'h00, 0, 0);
        check("neg_00", y, 8'h00);
        do_op(2'b11, 8'h80, 8'h00, 0, 0);
        check("neg_80", y, 8'h80);
        do_op(2'b11, 8'h7F, 8'h00, 0, 0);
        check("neg_7f", y, 8'h81);
        do_op(2'b01, 8'hF0, 8'h3C, 0, 0);
        check("and_f0_3c", y, 8'h30);
        do_op(2'b10, 8'hF0, 8'h3C, 0, 0);
        check("or_f0_3c", y, 8'hFC);

        do_op(2'b00, 8'h0F, 8'h00, 0, 1);
        check("disturb_not_0f", y, 8'hF0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_second_done", done, 0);
            check("no_requeue_busy", busy, 0);
        end

        do_op(2'b11, 8'h01, 8'h00, 0, 0);
        check("pre_abort_neg", y, 8'hFF);
        op    = 2'b00;
        a     = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        step();
        check("abort_y", y, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        start = 1'b0;
        rst_n = 1'b1;
        y_model = '0;
        for (int i = 0; i < N + 2; i++) begin
            step();
            check("abort_no_done", done, 0);
            check("abort_y_stays", y, 0);
        end
        do_op(2'b00, 8'h00, 8'h00, 0, 0);
        check("after_abort_not", y, 8'hFF);

        for (int i = 0; i < 4; i++)
            do_op(2'($urandom), N'($urandom), N'($urandom), 1, 0);
        start = 1'b0;
        step();

        for (int i = 0; i < 20; i++)
            do_op(2'($urandom), N'($urandom), N'($urandom), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
